// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
//   Shared definitions for the baccarat card datapath:
//     - card encoding constants (empty, ace, king)
//     - order-checker phase enum (DEAL, DRAW)
//     - card_value(): baccarat point value of a card, 0..9
// -----------------------------------------------------------------------------
package baccarat_pkg;

   localparam logic [3:0] CARD_EMPTY = 4'd0;
   localparam logic [3:0] CARD_ACE   = 4'd1;
   localparam logic [3:0] CARD_KING  = 4'd13;

   // Highest card that still counts at face value; 10, J, Q, K count as 0.
   localparam logic [3:0] CARD_NINE  = 4'd9;

   // Order-checker phase: the four opening cards, then the optional third cards.
   typedef enum logic {
      DEAL = 1'b0,
      DRAW = 1'b1
   } phase_t;

   // Baccarat point value: A..9 at face value, tens, faces and empty are 0.
   function automatic logic [3:0] card_value(input logic [3:0] card);
      if ((card >= CARD_ACE) && (card <= CARD_NINE)) begin
         return card;
      end
      return CARD_EMPTY;
   endfunction

endpackage : baccarat_pkg

// File: rtl/hand_score.sv
// -----------------------------------------------------------------------------
// hand_score
//   Purely combinational score of a three-card baccarat hand:
//   (val(card1) + val(card2) + val(card3)) mod 10.
//
// Ports
//   card1, card2, card3 in  [3:0] : card registers of one hand (0 = empty)
//   score               out [3:0] : hand score, 0..9
// -----------------------------------------------------------------------------
module hand_score
   import baccarat_pkg::*;
(
   input  logic [3:0] card1,
   input  logic [3:0] card2,
   input  logic [3:0] card3,
   output logic [3:0] score
);

   // Three values of at most 9 each sum to at most 27, so 5 bits hold it.
   logic [4:0] sum;

   always_comb begin
      sum   = 5'(card_value(card1)) + 5'(card_value(card2)) + 5'(card_value(card3));
      score = 4'(sum % 5'd10);
   end

endmodule : hand_score

// File: rtl/card_datapath.sv
// -----------------------------------------------------------------------------
// card_datapath
//   Datapath partner of the baccarat statemachine. A free-running deck counter
//   (1..13) supplies card values; six load strobes capture the counter into
//   six card registers; two hand_score instances return the player and dealer
//   scores combinationally. An order checker accepts strobes only in legal
//   dealing order and raises a sticky error flag otherwise.
//
// Ports
//   slow_clock          in       : clock, rising edge
//   resetb              in       : asynchronous active-low reset
//   load_pcard1..3      in       : player card load strobes
//   load_dcard1..3      in       : dealer card load strobes
//   seed_en             in       : preload the deck counter on this edge
//   seed_val            in  [3:0]: preload value (out of 1..13 loads 1)
//   pcard1..3_out       out [3:0]: player card registers (0 = empty)
//   dcard1..3_out       out [3:0]: dealer card registers (0 = empty)
//   pscore_out          out [3:0]: player score, 0..9
//   dscore_out          out [3:0]: dealer score, 0..9
//   cards_dealt         out [2:0]: number of legally loaded cards, 0..6
//   seq_err             out      : sticky dealing-order violation flag
// -----------------------------------------------------------------------------
module card_datapath
   import baccarat_pkg::*;
(
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       load_pcard1,
   input  logic       load_pcard2,
   input  logic       load_pcard3,
   input  logic       load_dcard1,
   input  logic       load_dcard2,
   input  logic       load_dcard3,
   input  logic       seed_en,
   input  logic [3:0] seed_val,
   output logic [3:0] pcard1_out,
   output logic [3:0] pcard2_out,
   output logic [3:0] pcard3_out,
   output logic [3:0] dcard1_out,
   output logic [3:0] dcard2_out,
   output logic [3:0] dcard3_out,
   output logic [3:0] pscore_out,
   output logic [3:0] dscore_out,
   output logic [2:0] cards_dealt,
   output logic       seq_err
);

   // Slot indices into the strobe vector and the card register array.
   localparam int unsigned S_P1 = 0;
   localparam int unsigned S_P2 = 1;
   localparam int unsigned S_P3 = 2;
   localparam int unsigned S_D1 = 3;
   localparam int unsigned S_D2 = 4;
   localparam int unsigned S_D3 = 5;

   logic [3:0] deck_q, deck_d;
   logic [3:0] card_q [6];
   logic [2:0] dealt_q;
   logic       err_q;
   phase_t     phase_q, phase_d;

   logic [5:0] strb;
   logic       one_hot;
   logic       legal;
   logic       err_set;
   logic [5:0] load;
   logic       p3_loaded, d3_loaded;

   assign strb = {load_dcard3, load_dcard2, load_dcard1,
                  load_pcard3, load_pcard2, load_pcard1};
   assign one_hot = $onehot(strb);

   // The deck never holds 0, so a non-empty register means that card was dealt.
   assign p3_loaded = (card_q[S_P3] != CARD_EMPTY);
   assign d3_loaded = (card_q[S_D3] != CARD_EMPTY);

   // ---------------------------------------------------------------------------
   // Deck counter next value: seed wins over the normal advance; the card
   // captured on this same edge still sees the current (pre-advance) value.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      deck_d = CARD_ACE;
      if (seed_en) begin
         if ((seed_val >= CARD_ACE) && (seed_val <= CARD_KING)) begin
            deck_d = seed_val;
         end
      end else if (deck_q != CARD_KING) begin
         deck_d = deck_q + 4'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Order checker: next phase and legality of this cycle's strobe.
   // Opening deal is strictly P1, D1, P2, D2 keyed off the dealt count; in the
   // draw phase P3 is only legal before either third card, D3 only once.
   // ---------------------------------------------------------------------------
   always_comb begin
      phase_d = phase_q;
      legal   = 1'b0;
      if (one_hot) begin
         case (phase_q)
            DEAL: begin
               legal = (strb[S_P1] && (dealt_q == 3'd0)) ||
                       (strb[S_D1] && (dealt_q == 3'd1)) ||
                       (strb[S_P2] && (dealt_q == 3'd2)) ||
                       (strb[S_D2] && (dealt_q == 3'd3));
               if (legal && strb[S_D2]) begin
                  phase_d = DRAW;
               end
            end
            DRAW: begin
               legal = (strb[S_P3] && !p3_loaded && !d3_loaded) ||
                       (strb[S_D3] && !d3_loaded);
            end
            default: begin
               phase_d = DEAL;
            end
         endcase
      end
      // Any strobe that is not a single legal one is a violation; a multi-hot
      // cycle loads nothing.
      err_set = (strb != 6'd0) && !legal;
      load    = legal ? strb : 6'd0;
   end

   // ---------------------------------------------------------------------------
   // State registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         // NOTE: non-blocking assignments throughout sequential logic so every
         // register samples pre-edge values regardless of statement order.
         deck_q  <= CARD_ACE;
         dealt_q <= 3'd0;
         err_q   <= 1'b0;
         phase_q <= DEAL;
      end else begin
         deck_q <= deck_d;
         phase_q <= phase_d;
         if (legal) begin
            dealt_q <= dealt_q + 3'd1;
         end
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   // NOTE: the card array is six ordinary flops, not a RAM, so it is reset
   // like any other state; "empty" must be visible straight out of reset.
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < 6; i++) begin
            card_q[i] <= CARD_EMPTY;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (load[i]) begin
               card_q[i] <= deck_q;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scores and outputs.
   // ---------------------------------------------------------------------------
   hand_score u_player_score (
      .card1 (card_q[S_P1]),
      .card2 (card_q[S_P2]),
      .card3 (card_q[S_P3]),
      .score (pscore_out)
   );

   hand_score u_dealer_score (
      .card1 (card_q[S_D1]),
      .card2 (card_q[S_D2]),
      .card3 (card_q[S_D3]),
      .score (dscore_out)
   );

   assign pcard1_out  = card_q[S_P1];
   assign pcard2_out  = card_q[S_P2];
   assign pcard3_out  = card_q[S_P3];
   assign dcard1_out  = card_q[S_D1];
   assign dcard2_out  = card_q[S_D2];
   assign dcard3_out  = card_q[S_D3];
   assign cards_dealt = dealt_q;
   assign seq_err     = err_q;

endmodule : card_datapath

// File: doc/card_datapath.md
# card_datapath

Datapath partner of the baccarat statemachine: consumes the six `load_*` strobes it issues, captures dealt cards from an internal rotating deck counter into six card registers, and returns `pscore_out`, `dscore_out` and `pcard3_out` for its draw decisions. It also checks that strobes arrive in legal dealing order and flags any violation. It sits between the statemachine and the display logic on the slow clock domain.

## Interface
- No parameters; card width fixed at 4 bits, score width 4 bits.
- `slow_clock` in 1: sole clock, rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `load_pcard1`, `load_pcard2`, `load_pcard3` in 1 each: player card load strobes from the statemachine.
- `load_dcard1`, `load_dcard2`, `load_dcard3` in 1 each: dealer card load strobes.
- `seed_en` in 1: preload the deck counter, for deterministic test and demo.
- `seed_val` in 4: preload value.
- `pcard1_out`, `pcard2_out`, `pcard3_out` out 4 each: player card registers. 0 = empty; 1 = A; 2..10; 11 = J; 12 = Q; 13 = K.
- `dcard1_out`, `dcard2_out`, `dcard3_out` out 4 each: dealer card registers.
- `pscore_out`, `dscore_out` out 4 each: hand scores, 0..9.
- `cards_dealt` out 3: count of legally loaded cards, 0..6.
- `seq_err` out 1: sticky protocol-violation flag.

## Operation
- **Deck counter.** 4-bit register, range 1..13.
  - Advances by 1 every clock; 13 wraps to 1.
  - When `seed_en`=1, the next value is `seed_val` if it is in 1..13, otherwise 1.
- **Card load.** On an edge with exactly one strobe high, the addressed card register captures the deck counter's current (pre-advance) value.
  - When `seed_en` and a strobe are high in the same cycle, the card takes the current counter value and the seed affects only the next value.
- **Card value.** 1..9 gives face value; 10..13 and empty give 0.
- **Score.** pscore = (val(p1) + val(p2) + val(p3)) mod 10; dscore is the same over the dealer cards.
  - Both scores are combinational from the card registers, so they are valid in the cycle after the loading edge.
  - Sum width is 5 bits before the mod.
- **Order checker.** Two-phase FSM with a dealt counter.
  - DEAL phase expects, in sequence: P1 at count 0, D1 at 1, P2 at 2, D2 at 3.
  - After D2 the FSM enters DRAW phase. P3 is legal only while neither P3 nor D3 is loaded. D3 is legal once.
  - A legal strobe loads the register and increments `cards_dealt`.
  - An illegal strobe sets `seq_err` and leaves registers and count unchanged. Illegal means out of order, a repeat, or anything after D3.
  - Two or more strobes high in one cycle: nothing loads, `seq_err` is set.
- `seq_err` is cleared only by reset.

## Timing
- **Reset values.** All card registers 0, `pscore_out`=0, `dscore_out`=0, `cards_dealt`=0, `seq_err`=0, deck counter 1, FSM in DEAL.
- **Reset mid-hand.** Asserting `resetb` low clears all of the above immediately, independent of the clock.
- **Latency.** The card register and `cards_dealt` update at the strobe edge. Scores settle in the same cycle after that edge, before the next edge, so the statemachine can sample them in its next state.
- Strobes are level-sampled, one cycle each. A strobe held for two cycles counts as a repeat and sets `seq_err`.

## Structure
- Shared package `baccarat_pkg` holds:
  - card encoding constants: `CARD_EMPTY`=0, `CARD_ACE`=1, `CARD_KING`=13;
  - the checker phase enum (DEAL, DRAW);
  - function `card_value(card)` returning 0..9.
- One sub-module, `hand_score`: takes three cards and returns the mod-10 score. It is instantiated twice, once for the player and once for the dealer.

## Test plan
- **Reset.** Hold `resetb`=0 with strobes toggling -> all cards 0, scores 0, `cards_dealt`=0, `seq_err`=0.
- **Normal deal.** `seed_en` with `seed_val`=1 for one cycle, then P1, D1, P2, D2 on consecutive cycles -> cards 1, 2, 3, 4; `pscore_out`=4, `dscore_out`=6, `cards_dealt`=4. Next cycle P3 -> `pcard3_out`=5, `pscore_out`=9.
- **Face cards.** Seed 10, then deal P1..D2 -> cards 10, 11, 12, 13; both scores 0. Seed 7 then D3 -> `dcard3_out`=7, `dscore_out`=7.
- **Wrap.** Seed 13, then P1, D1 -> `pcard1_out`=13, `dcard1_out`=1.
- **Order error.** Fire D1 immediately after reset -> `dcard1_out`=0, `cards_dealt`=0, `seq_err`=1 and it stays 1 until reset. Fire P1 and D1 in the same cycle after a fresh reset -> no load, `seq_err`=1.
- **Late P3.** After a full deal, D3 then P3 -> P3 is rejected, `pcard3_out`=0, `seq_err`=1, `cards_dealt`=5.
